// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if
//  Bundles the game controller's frame/paddle inputs and ball/score outputs.
//  slave  : the controller (consumes frame tick, start, paddle geometry; drives ball/score)
//  master : the surrounding system (timing generator, player blocks, renderers)
//  Signals:
//   i_frame_tick  1  one-cycle pulse per frame
//   i_start       1  debounced start button, level
//   i_y1/i_y2     9  paddle top rows
//   i_h1/i_h2     7  paddle heights
//   o_ball_x/y    9  ball top-left corner
//   o_ball_en     1  ball visible
//   o_score1/2    4  player scores
//   o_state       2  0 IDLE, 1 SERVE, 2 PLAY, 3 OVER
//   o_point       1  one-cycle pulse when a point is scored
interface pong_game_ctrl_if;
    logic       i_frame_tick;
    logic       i_start;
    logic [8:0] i_y1;
    logic [8:0] i_y2;
    logic [6:0] i_h1;
    logic [6:0] i_h2;
    logic [8:0] o_ball_x;
    logic [8:0] o_ball_y;
    logic       o_ball_en;
    logic [3:0] o_score1;
    logic [3:0] o_score2;
    logic [1:0] o_state;
    logic       o_point;

    modport master (
        output i_frame_tick, i_start, i_y1, i_y2, i_h1, i_h2,
        input  o_ball_x, o_ball_y, o_ball_en, o_score1, o_score2, o_state, o_point
    );

    modport slave (
        input  i_frame_tick, i_start, i_y1, i_y2, i_h1, i_h2,
        output o_ball_x, o_ball_y, o_ball_en, o_score1, o_score2, o_state, o_point
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//  Two-player pong sequencer: ball motion, wall bounces, paddle hits, scoring,
//  serve delay and game-over. All outputs come straight from registers.
//  Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous reset, active low
//   bus      pong_game_ctrl_if.slave (frame tick, start, paddles in; ball, scores, state out)
module pong_game_ctrl #(
    parameter int SCREEN_W     = 480,
    parameter int SCREEN_H     = 272,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 6,
    parameter int P1_X         = 0,
    parameter int P2_X         = 474,
    parameter int SPEED        = 2,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    pong_game_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    // Geometry is evaluated in 10 bits so sums near the screen edge cannot wrap.
    localparam logic [8:0]       CX       = 9'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [8:0]       CY       = 9'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]       BALL     = 10'(BALL_SIZE);
    localparam logic [9:0]       SPD      = 10'(SPEED);
    localparam logic [9:0]       HMAX     = 10'(SCREEN_H);
    localparam logic [9:0]       YBOT     = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0]       LEFT_LIM = 10'(P1_X + PADDLE_W + SPEED);
    localparam logic [9:0]       LEFT_X   = 10'(P1_X + PADDLE_W);
    localparam logic [9:0]       RIGHT_LIM = 10'(P2_X);
    localparam logic [9:0]       RIGHT_X  = 10'(P2_X - BALL_SIZE);
    localparam logic [3:0]       WIN      = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_N  = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [8:0]       x_q, x_d, y_q, y_d;
    logic             dx_q, dx_d, dy_q, dy_d;   // 1 = moving toward larger coordinate
    logic [3:0]       s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q;
    logic             en_q, en_d;
    logic             point_q, point_d;

    logic [9:0]       x10_s, y10_s, nx_s, ny_s, bot1_s, bot2_s;
    logic             ndx_s, ndy_s, hit1_s, hit2_s, miss1_s, miss2_s, start_edge_s;
    logic [3:0]       s1_inc_s, s2_inc_s;
    logic [CNT_W-1:0] cnt_inc_s;

    assign x10_s        = {1'b0, x_q};
    assign y10_s        = {1'b0, y_q};
    assign bot1_s       = {1'b0, bus.i_y1} + {3'b000, bus.i_h1};
    assign bot2_s       = {1'b0, bus.i_y2} + {3'b000, bus.i_h2};
    assign hit1_s       = ((y10_s + BALL) > {1'b0, bus.i_y1}) && (y10_s < bot1_s);
    assign hit2_s       = ((y10_s + BALL) > {1'b0, bus.i_y2}) && (y10_s < bot2_s);
    assign start_edge_s = bus.i_start & ~start_q;
    assign s1_inc_s     = s1_q + 4'd1;
    assign s2_inc_s     = s2_q + 4'd1;
    assign cnt_inc_s    = cnt_q + CNT_ONE;

    // Candidate next ball position/direction for a play tick, plus miss detection.
    always_comb begin
        ny_s    = y10_s;
        ndy_s   = dy_q;
        nx_s    = x10_s;
        ndx_s   = dx_q;
        miss1_s = 1'b0;
        miss2_s = 1'b0;
        if (!dy_q && (y10_s < SPD)) begin
            ny_s  = 10'd0;
            ndy_s = 1'b1;
        end else if (dy_q && ((y10_s + BALL + SPD) > HMAX)) begin
            ny_s  = YBOT;
            ndy_s = 1'b0;
        end else if (dy_q) begin
            ny_s = y10_s + SPD;
        end else begin
            ny_s = y10_s - SPD;
        end
        if (!dx_q && (x10_s < LEFT_LIM)) begin
            if (hit1_s) begin
                nx_s  = LEFT_X;
                ndx_s = 1'b1;
            end else begin
                miss1_s = 1'b1;
            end
        end else if (dx_q && ((x10_s + BALL + SPD) > RIGHT_LIM)) begin
            if (hit2_s) begin
                nx_s  = RIGHT_X;
                ndx_s = 1'b0;
            end else begin
                miss2_s = 1'b1;
            end
        end else if (dx_q) begin
            nx_s = x10_s + SPD;
        end else begin
            nx_s = x10_s - SPD;
        end
    end

    // Game sequencer next-state and register updates.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        cnt_d   = cnt_q;
        point_d = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (start_edge_s) begin
                    state_d = S_SERVE;
                    s1_d    = 4'd0;
                    s2_d    = 4'd0;
                    cnt_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SERVE: begin
                if (bus.i_frame_tick) begin
                    cnt_d = cnt_inc_s;
                    if (cnt_inc_s == SERVE_N) begin
                        state_d = S_PLAY;
                    end else begin
                        state_d = S_SERVE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_PLAY: begin
                if (bus.i_frame_tick && (miss1_s || miss2_s)) begin
                    // Recentre and serve toward the player who conceded; dy is kept.
                    point_d = 1'b1;
                    x_d     = CX;
                    y_d     = CY;
                    cnt_d   = '0;
                    if (miss1_s) begin
                        dx_d    = 1'b0;
                        s2_d    = s2_inc_s;
                        state_d = (s2_inc_s == WIN) ? S_OVER : S_SERVE;
                    end else begin
                        dx_d    = 1'b1;
                        s1_d    = s1_inc_s;
                        state_d = (s1_inc_s == WIN) ? S_OVER : S_SERVE;
                    end
                end else if (bus.i_frame_tick) begin
                    x_d  = nx_s[8:0];
                    y_d  = ny_s[8:0];
                    dx_d = ndx_s;
                    dy_d = ndy_s;
                end else begin
                    state_d = S_PLAY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        en_d = (state_d == S_SERVE) || (state_d == S_PLAY);
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            x_q     <= CX;
            y_q     <= CY;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            s1_q    <= 4'd0;
            s2_q    <= 4'd0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            en_q    <= 1'b0;
            point_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            start_q <= bus.i_start;
            en_q    <= en_d;
            point_q <= point_d;
        end
    end

    assign bus.o_ball_x  = x_q;
    assign bus.o_ball_y  = y_q;
    assign bus.o_ball_en = en_q;
    assign bus.o_score1  = s1_q;
    assign bus.o_score2  = s2_q;
    assign bus.o_state   = state_q;
    assign bus.o_point   = point_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl
//  Self-checking bench for pong_game_ctrl: a vector table for the start/serve
//  sequence, hand sequences for win/over/reset, and random play compared every
//  cycle against a behavioural model of the game rules.
module tb_pong_game_ctrl;
    localparam int SW = 480, SH = 272, BS = 8, PW = 6, P2X = 474, SP = 2;
    localparam int CXE = 236, CYE = 132, WINS = 7, SERVE = 60;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    pong_game_ctrl_if bus();

    pong_game_ctrl dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int m_state, m_x, m_y, m_dx, m_dy, m_s1, m_s2, m_cnt, m_en, m_point;
    bit m_prev;

    // paddle drive modes: 0 fixed, 1 follow model ball, 2 random
    int p1_mode, p2_mode, fix_y1, fix_h1, fix_y2, fix_h2;

    typedef struct {
        bit tick;
        bit start;
        int exp_state;
        int exp_en;
        int exp_x;
        int exp_y;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = 0; m_x = CXE; m_y = CYE; m_dx = 1; m_dy = 1;
        m_s1 = 0; m_s2 = 0; m_cnt = 0; m_en = 0; m_point = 0; m_prev = 1'b0;
    endfunction

    function automatic bool_overlap(input int y, input int py, input int ph);
        return (y + BS > py) && (y < py + ph);
    endfunction

    function automatic void model_step(input bit tick, input bit start,
                                       input int y1, input int h1, input int y2, input int h2);
        bit edge_s;
        int ny, ndy, nx, ndx, missed;
        edge_s  = start && !m_prev;
        m_prev  = start;
        m_point = 0;
        if (m_state == 0 || m_state == 3) begin
            if (edge_s) begin
                m_state = 1; m_s1 = 0; m_s2 = 0; m_cnt = 0;
            end
        end else if (m_state == 1) begin
            if (tick) begin
                m_cnt++;
                if (m_cnt == SERVE) m_state = 2;
            end
        end else if (tick) begin
            ny = m_y + SP * m_dy; ndy = m_dy;
            nx = m_x + SP * m_dx; ndx = m_dx;
            missed = 0;
            if (m_dy < 0 && m_y < SP) begin ny = 0; ndy = 1; end
            else if (m_dy > 0 && m_y + BS + SP > SH) begin ny = SH - BS; ndy = -1; end
            if (m_dx < 0 && m_x < PW + SP) begin
                if (bool_overlap(m_y, y1, h1)) begin nx = PW; ndx = 1; end
                else missed = 1;
            end else if (m_dx > 0 && m_x + BS + SP > P2X) begin
                if (bool_overlap(m_y, y2, h2)) begin nx = P2X - BS; ndx = -1; end
                else missed = 2;
            end
            if (missed != 0) begin
                m_point = 1; m_x = CXE; m_y = CYE; m_cnt = 0;
                if (missed == 1) begin m_dx = -1; m_s2++; end
                else begin m_dx = 1; m_s1++; end
                m_state = (m_s1 == WINS || m_s2 == WINS) ? 3 : 1;
            end else begin
                m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
            end
        end
        m_en = (m_state == 1 || m_state == 2) ? 1 : 0;
    endfunction

    task automatic compare_all();
        chk("state", bus.o_state, m_state);
        chk("ball_x", bus.o_ball_x, m_x);
        chk("ball_y", bus.o_ball_y, m_y);
        chk("ball_en", bus.o_ball_en, m_en);
        chk("score1", bus.o_score1, m_s1);
        chk("score2", bus.o_score2, m_s2);
        chk("point", bus.o_point, m_point);
    endtask

    task automatic set_paddles();
        case (p1_mode)
            0:       begin bus.i_y1 = 9'(fix_y1); bus.i_h1 = 7'(fix_h1); end
            1:       begin bus.i_y1 = 9'(m_y); bus.i_h1 = 7'd8; end
            default: begin bus.i_y1 = 9'($urandom_range(0, 271)); bus.i_h1 = 7'($urandom_range(0, 127)); end
        endcase
        case (p2_mode)
            0:       begin bus.i_y2 = 9'(fix_y2); bus.i_h2 = 7'(fix_h2); end
            1:       begin bus.i_y2 = 9'(m_y); bus.i_h2 = 7'd8; end
            default: begin bus.i_y2 = 9'($urandom_range(0, 271)); bus.i_h2 = 7'($urandom_range(0, 127)); end
        endcase
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, compare 1 ns later.
    task automatic cycle(input bit tick, input bit start);
        set_paddles();
        bus.i_frame_tick = tick;
        bus.i_start      = start;
        @(posedge clk);
        model_step(tick, start, int'(bus.i_y1), int'(bus.i_h1), int'(bus.i_y2), int'(bus.i_h2));
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic frame();
        cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, bus.o_state, 0);
        chk({tag, "_x"}, bus.o_ball_x, CXE);
        chk({tag, "_y"}, bus.o_ball_y, CYE);
        chk({tag, "_en"}, bus.o_ball_en, 0);
        chk({tag, "_s1"}, bus.o_score1, 0);
        chk({tag, "_s2"}, bus.o_score2, 0);
        chk({tag, "_point"}, bus.o_point, 0);
    endtask

    initial begin
        int guard;
        int pts_seen;
        bit done;

        tbl[0] = '{1'b1, 1'b0, 0, 0, CXE, CYE};  // tick in IDLE ignored
        tbl[1] = '{1'b0, 1'b1, 1, 1, CXE, CYE};  // start edge -> SERVE
        tbl[2] = '{1'b0, 1'b1, 1, 1, CXE, CYE};  // held level is not an edge
        tbl[3] = '{1'b0, 1'b0, 1, 1, CXE, CYE};
        tbl[4] = '{1'b1, 1'b1, 1, 1, CXE, CYE};  // edge ignored in SERVE, count 1
        tbl[5] = '{1'b1, 1'b0, 1, 1, CXE, CYE};  // count 2

        p1_mode = 0; p2_mode = 0;
        fix_y1 = 100; fix_h1 = 40; fix_y2 = 100; fix_h2 = 40;
        bus.i_frame_tick = 1'b0; bus.i_start = 1'b0;
        bus.i_y1 = 9'd0; bus.i_h1 = 7'd0; bus.i_y2 = 9'd0; bus.i_h2 = 7'd0;
        model_reset();

        // reset state
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;

        // start/serve vectors
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].tick, tbl[i].start);
            chk("vec_state", bus.o_state, tbl[i].exp_state);
            chk("vec_en", bus.o_ball_en, tbl[i].exp_en);
            chk("vec_x", bus.o_ball_x, tbl[i].exp_x);
            chk("vec_y", bus.o_ball_y, tbl[i].exp_y);
            chk("vec_point", bus.o_point, 0);
        end

        // ticks 3..59 keep serving, tick 60 enters PLAY with ball still at centre
        for (int i = 3; i < SERVE; i++) begin
            frame();
            chk("serve_hold", bus.o_state, 1);
        end
        frame();
        chk("serve_to_play", bus.o_state, 2);
        chk("serve_centre_x", bus.o_ball_x, CXE);

        // rally with both paddles tracking: wall bounces and paddle hits only
        p1_mode = 1; p2_mode = 1;
        for (int i = 0; i < 300; i++) frame();
        chk("rally_s1", bus.o_score1, 0);
        chk("rally_s2", bus.o_score2, 0);
        chk("rally_state", bus.o_state, 2);

        // random paddles, random tick spacing, occasional start presses
        p1_mode = 2; p2_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            cycle(1'b1, ($urandom_range(0, 15) == 0));
            repeat ($urandom_range(0, 3)) cycle(1'b0, ($urandom_range(0, 15) == 0));
        end

        // fresh game; player 1 always misses, player 2 always returns
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        p1_mode = 0; fix_y1 = 400; fix_h1 = 10;
        p2_mode = 1;
        guard = 0; pts_seen = 0; done = 1'b0;
        while (!done && guard < 4000) begin
            cycle(1'b1, 1'b0);
            if (m_point == 1) begin
                pts_seen++;
                chk("miss_point", bus.o_point, 1);
                chk("miss_dx_centre", bus.o_ball_x, CXE);
                cycle(1'b0, 1'b0);
                chk("point_one_cycle", bus.o_point, 0);
            end
            if (m_state == 3) done = 1'b1;
            cycle(1'b0, 1'b0);
            guard++;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL win_timeout: got state %0d want 3 within 4000 frames", bus.o_state);
        end
        chk("win_points", pts_seen, WINS);
        chk("over_state", bus.o_state, 3);
        chk("over_s2", bus.o_score2, 7);
        chk("over_s1", bus.o_score1, 0);
        chk("over_en", bus.o_ball_en, 0);
        for (int i = 0; i < 10; i++) frame();
        chk("over_hold_state", bus.o_state, 3);
        chk("over_hold_s2", bus.o_score2, 7);
        cycle(1'b0, 1'b1);
        chk("restart_state", bus.o_state, 1);
        chk("restart_s2", bus.o_score2, 0);
        chk("restart_en", bus.o_ball_en, 1);
        cycle(1'b0, 1'b0);

        // play on until player 2 has points and the ball is mid-flight, then reset mid-cycle
        guard = 0; done = 1'b0;
        while (!done && guard < 2000) begin
            frame();
            if (m_s2 >= 2 && m_state == 2 && m_x < 200) done = 1'b1;
            guard++;
        end
        if (!done) begin
            bad++;
            total++;
            $display("FAIL midplay_timeout: got score2 %0d want >=2 in PLAY", bus.o_score2);
        end
        chk("pre_rst_s2", (bus.o_score2 >= 4'd2), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0);
        chk("post_rst_idle", bus.o_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
